display_eight_reader: RTL and testbench

- Reverse direction of the two-digit hex seven-segment display path: accepts the two 7-bit active-low segment buses driving the LEDs and recovers the 8-bit value they show.
- Used for on-board loopback self-check and for reading segment patterns back from the display bus.
- Filters glitches by requiring a stable pattern for a number of cycles before reporting it.
- Presents each newly recovered byte on a valid/ready output with per-digit error flags for illegal patterns.

---
 rtl/display_pkg.sv | 27 ++
 rtl/display_eight_reader_seg_to_nibble.sv | 32 +++
 rtl/display_eight_reader.sv | 114 +++++++++++
 tb/tb_display_eight_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Segment encodings and state type shared by the seven-segment readback path.
package display_pkg;
  localparam int NUM_DIGITS = 2;
  localparam int SEG_W      = 7;
  localparam int NIB_W      = 4;

  // Active-low, bit0=a .. bit6=g
  localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic {TRACK, PENDING} state_t;
endpackage

// File: rtl/display_eight_reader_seg_to_nibble.sv
// Combinational seven-segment to hex nibble decoder; unknown patterns flag illegal and read 0.
module seg_to_nibble
  import display_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output logic [NIB_W-1:0] o_nib,
  output logic             o_err
);
  always_comb begin
    o_nib = '0;
    o_err = 1'b0;
    case (i_seg)
      SEG_HEX_0: o_nib = 4'h0;
      SEG_HEX_1: o_nib = 4'h1;
      SEG_HEX_2: o_nib = 4'h2;
      SEG_HEX_3: o_nib = 4'h3;
      SEG_HEX_4: o_nib = 4'h4;
      SEG_HEX_5: o_nib = 4'h5;
      SEG_HEX_6: o_nib = 4'h6;
      SEG_HEX_7: o_nib = 4'h7;
      SEG_HEX_8: o_nib = 4'h8;
      SEG_HEX_9: o_nib = 4'h9;
      SEG_HEX_A: o_nib = 4'hA;
      SEG_HEX_B: o_nib = 4'hB;
      SEG_HEX_C: o_nib = 4'hC;
      SEG_HEX_D: o_nib = 4'hD;
      SEG_HEX_E: o_nib = 4'hE;
      SEG_HEX_F: o_nib = 4'hF;
      default:   o_err = 1'b1;
    endcase
  end
endmodule

// File: rtl/display_eight_reader.sv
// Recovers the byte shown on a two-digit seven-segment bus after a stability filter.
// Optional drop counter enabled by DISPLAY_READER_DROP_CNT_EN.
module display_eight_reader
  import display_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEG_W-1:0]     first_led,
  input  logic [SEG_W-1:0]     second_led,
  output logic [7:0]           out_data,
  output logic [1:0]           out_err,
  output logic                 out_valid,
`ifdef DISPLAY_READER_DROP_CNT_EN
  output logic [7:0]           drop_count,
  input  logic                 drop_clear,
`endif
  input  logic                 out_ready
);
  localparam int PAIR_W = NUM_DIGITS * SEG_W;
  localparam logic [CNT_W-1:0] STB    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STB_M1 = CNT_W'(STABLE_CYCLES - 1);

  logic [PAIR_W-1:0] r_samp;
  logic [CNT_W-1:0]  r_cnt;
  logic [PAIR_W-1:0] r_last;
  logic              r_last_vld;
  state_t            r_state;
  logic [7:0]        r_data;
  logic [1:0]        r_err;

  logic [PAIR_W-1:0]                       w_in;
  logic                                    w_eq, w_qual, w_new, w_hs;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]        w_seg;
  logic [NUM_DIGITS-1:0][NIB_W-1:0]        w_nib;
  logic [NUM_DIGITS-1:0]                   w_err;

  assign w_in   = {second_led, first_led};
  assign w_eq   = (w_in == r_samp);
  assign w_qual = w_eq && (r_cnt == STB_M1);
  // Only a pair that differs from the last one emitted counts as new
  assign w_new  = w_qual && (!r_last_vld || (r_samp != r_last));
  assign w_hs   = (r_state == PENDING) && out_ready;
  assign w_seg  = r_samp;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    seg_to_nibble u_dec (
      .i_seg (w_seg[g]),
      .o_nib (w_nib[g]),
      .o_err (w_err[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp <= {PAIR_W{1'b1}};
      r_cnt  <= '0;
    end else begin
      r_samp <= w_in;
      if (!w_eq)            r_cnt <= '0;
      else if (r_cnt != STB) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= TRACK;
      r_data     <= '0;
      r_err      <= '0;
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else begin
      case (r_state)
        TRACK: if (w_new) begin
          r_data     <= w_nib;
          r_err      <= w_err;
          r_last     <= r_samp;
          r_last_vld <= 1'b1;
          r_state    <= PENDING;
        end
        PENDING: if (w_hs) begin
          if (w_new) begin
            r_data     <= w_nib;
            r_err      <= w_err;
            r_last     <= r_samp;
            r_last_vld <= 1'b1;
          end else begin
            r_state <= TRACK;
          end
        end
        default: r_state <= TRACK;
      endcase
    end
  end

`ifdef DISPLAY_READER_DROP_CNT_EN
  logic       w_drop;
  logic [7:0] r_drop;
  assign w_drop = (r_state == PENDING) && !out_ready && w_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_drop <= '0;
    else if (drop_clear)               r_drop <= '0;
    else if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
  end
  assign drop_count = r_drop;
`endif

  assign out_data  = r_data;
  assign out_err   = r_err;
  assign out_valid = (r_state == PENDING);
endmodule

// File: tb/tb_display_eight_reader.sv
// Directed plus randomized bench for display_eight_reader against a history-based reference model.
module tb_display_eight_reader;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] first_led, second_led;
  logic       out_ready;
  logic       drop_clear;
  logic [7:0] out_data;
  logic [1:0] out_err;
  logic       out_valid;
`ifdef DISPLAY_READER_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  always #5 clk = ~clk;

  display_eight_reader #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .first_led  (first_led),
    .second_led (second_led),
    .out_data   (out_data),
    .out_err    (out_err),
    .out_valid  (out_valid),
`ifdef DISPLAY_READER_DROP_CNT_EN
    .drop_count (drop_count),
    .drop_clear (drop_clear),
`endif
    .out_ready  (out_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // {illegal, nibble}
  function automatic logic [4:0] ref_dec(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (p == seg_tab[i]) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  // Reference: a pair qualifies on the edge where its run of identical samples
  // (the reset sample 3FFF counts as held) reaches exactly S+1.
  logic [13:0] hist [$];
  bit          m_valid, m_last_vld;
  logic [13:0] m_last;
  logic [7:0]  m_data;
  logic [1:0]  m_err;
  int          m_drops;

  task automatic model_reset();
    hist = {};
    hist.push_back(14'h3FFF);
    m_valid = 0; m_last_vld = 0; m_last = '0;
    m_data = '0; m_err = '0; m_drops = 0;
  endtask

  task automatic model_edge();
    logic [13:0] p;
    logic [4:0]  d0, d1;
    int          n;
    bit          distinct, hs;
    p  = {second_led, first_led};
    hs = m_valid && out_ready;
    hist.push_back(p);
    if (hist.size() > S + 2) void'(hist.pop_front());
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != p) break;
      n++;
    end
    distinct = (n == S + 1) && (!m_last_vld || p != m_last);
    if (drop_clear) m_drops = 0;
    else if (m_valid && !hs && distinct && m_drops < 255) m_drops++;
    if (distinct && (!m_valid || hs)) begin
      d0 = ref_dec(first_led);
      d1 = ref_dec(second_led);
      m_data = {d1[3:0], d0[3:0]};
      m_err  = {d1[4], d0[4]};
      m_last = p; m_last_vld = 1;
      m_valid = 1;
    end else if (hs) begin
      m_valid = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", out_valid, m_valid);
    chk("data", out_data, m_data);
    chk("err", out_err, m_err);
`ifdef DISPLAY_READER_DROP_CNT_EN
    chk("drops", drop_count, m_drops);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_err", out_err, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k = 0;
    while (!out_valid && k < max) begin step(); k++; end
    chk(tag, out_valid, 1);
  endtask

  initial begin
    int cnt;
    logic [7:0] seen;
    first_led = 7'h12; second_led = 7'h30; out_ready = 1'b1; drop_clear = 1'b0;
    do_reset();

    // Basic emission of 0x35 with consumer ready
    repeat (S) step();
    chk("t1_early", out_valid, 0);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 8'h35);
    chk("t1_err", out_err, 2'b00);
    step();
    cnt = 0;
    repeat (8) begin step(); if (out_valid) cnt++; end
    chk("t1_once", cnt, 0);

    // Glitch: short-lived 00 must not be emitted, 01 must be emitted once
    first_led = 7'h40; second_led = 7'h40;
    do_reset();
    repeat (2) step();
    first_led = 7'h79;
    cnt = 0; seen = '0;
    repeat (12) begin
      step();
      if (out_valid) begin cnt++; seen = out_data; end
    end
    chk("t2_count", cnt, 1);
    chk("t2_data", seen, 8'h01);

    // Illegal low digit
    first_led = 7'h7F; second_led = 7'h0E;
    do_reset();
    wait_valid("t3_timeout", 10);
    chk("t3_data", out_data, 8'hF0);
    chk("t3_err", out_err, 2'b01);

    // Backpressure: 4C qualifies while A3 pending and is dropped
    out_ready = 1'b0;
    first_led = 7'h30; second_led = 7'h08;
    do_reset();
    wait_valid("t4_timeout", 10);
    chk("t4_data", out_data, 8'hA3);
    first_led = 7'h46; second_led = 7'h19;
    repeat (10) step();
    chk("t4_hold", out_data, 8'hA3);
    chk("t4_hold_v", out_valid, 1);
`ifdef DISPLAY_READER_DROP_CNT_EN
    chk("t4_drop", drop_count, 8'd1);
`endif
    out_ready = 1'b1;
    step();
    chk("t4_accept", out_valid, 0);
    cnt = 0;
    repeat (6) begin step(); if (out_valid) cnt++; end
    chk("t4_no4c", cnt, 0);

    // Handshake on the same edge that qualifies a new pair
    out_ready = 1'b0;
    first_led = 7'h24; second_led = 7'h79;
    do_reset();
    wait_valid("t5_timeout", 10);
    chk("t5_first", out_data, 8'h12);
    first_led = 7'h06; second_led = 7'h78;
    repeat (S) step();
    out_ready = 1'b1;
    step();
    chk("t5_valid", out_valid, 1);
    chk("t5_data", out_data, 8'h7E);
    step();
    chk("t5_done", out_valid, 0);

    // Reset while pending, then re-emission latency
    out_ready = 1'b0;
    first_led = 7'h02; second_led = 7'h46;
    wait_valid("t6_timeout", 10);
    chk("t6_data", out_data, 8'hC6);
    #2;
    do_reset();
    cnt = 0;
    while (!out_valid && cnt < 20) begin step(); cnt++; end
    chk("t6_lat", cnt, S + 1);
    chk("t6_redata", out_data, 8'hC6);

    // Randomized patterns, hold times, backpressure and clears
    do_reset();
    repeat (400) begin
      int hold;
      first_led  = ($urandom_range(0, 99) < 85) ? seg_tab[$urandom_range(0, 15)] : 7'($urandom);
      second_led = ($urandom_range(0, 99) < 85) ? seg_tab[$urandom_range(0, 15)] : 7'($urandom);
      hold = $urandom_range(1, S + 4);
      repeat (hold) begin
        out_ready  = ($urandom_range(0, 99) < 60);
        drop_clear = ($urandom_range(0, 99) < 5);
        step();
      end
    end
    drop_clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
